// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MULS = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIVS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Start/busy/done request and result bundle between the decoder and muldiv_unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             i_start;
    op_e              i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_lo;
    logic [WIDTH-1:0] o_hi;
    logic             o_ovf;
    logic             o_dz;
    logic             o_zf;

    modport master (
        output i_start, i_op, i_a, i_b,
        input  o_busy, o_done, o_lo, o_hi, o_ovf, o_dz, o_zf
    );

    modport slave (
        input  i_start, i_op, i_a, i_b,
        output o_busy, o_done, o_lo, o_hi, o_ovf, o_dz, o_zf
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_mode,
    input  logic [2*WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH:0]   o_acc,
    output logic               o_carry
);
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shRem;
    logic [WIDTH:0]   w_diff;

    assign w_hi = i_acc[2*WIDTH-1:WIDTH];
    assign w_lo = i_acc[WIDTH-1:0];

    // Divide leaves quo[0] clear; the caller fills it from the inverted borrow.
    always_comb begin
        w_sum   = {i_acc[2*WIDTH], w_hi} + {1'b0, i_operand};
        w_shRem = {w_hi, w_lo[WIDTH-1]};
        w_diff  = w_shRem - {1'b0, i_operand};
        o_acc   = '0;
        o_carry = 1'b0;
        if (!i_mode) begin
            o_carry = w_lo[0] & w_sum[WIDTH];
            if (w_lo[0]) begin
                o_acc = {1'b0, w_sum, w_lo[WIDTH-1:1]};
            end else begin
                o_acc = {1'b0, i_acc[2*WIDTH:WIDTH], w_lo[WIDTH-1:1]};
            end
        end else begin
            o_carry = w_diff[WIDTH];
            if (w_diff[WIDTH]) begin
                o_acc = {1'b0, w_shRem[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
            end else begin
                o_acc = {1'b0, w_diff[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide sequencer with start/busy/done handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             r_state;
    op_e                r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic               r_negP;
    logic               r_negQ;
    logic               r_negR;
    logic               r_ovfCase;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic               r_ovf;
    logic               r_dz;
    logic               r_zf;

    logic               w_accept;
    logic               w_isDivIn;
    logic               w_signA;
    logic               w_signB;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic               w_dzIn;
    logic               w_ovfCaseIn;
    logic [2*WIDTH:0]   w_accInit;
    logic [WIDTH-1:0]   w_operandIn;
    logic               w_opDiv;
    logic [2*WIDTH:0]   w_stepAcc;
    logic               w_carry;
    logic [2*WIDTH:0]   w_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_loFix;
    logic [WIDTH-1:0]   w_hiFix;
    logic               w_ovfFix;

    assign w_accept    = bus.i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_isDivIn   = (bus.i_op == OP_DIVU) | (bus.i_op == OP_DIVS);
    assign w_signA     = ((bus.i_op == OP_MULS) | (bus.i_op == OP_DIVS)) & bus.i_a[WIDTH-1];
    assign w_signB     = ((bus.i_op == OP_MULS) | (bus.i_op == OP_DIVS)) & bus.i_b[WIDTH-1];
    // Negating MIN yields MIN again, which read unsigned is exactly its magnitude.
    assign w_absA      = w_signA ? (~bus.i_a + 1'b1) : bus.i_a;
    assign w_absB      = w_signB ? (~bus.i_b + 1'b1) : bus.i_b;
    assign w_dzIn      = w_isDivIn & (bus.i_b == '0);
    assign w_ovfCaseIn = (bus.i_op == OP_DIVS) & (bus.i_a == MIN_VAL) & (bus.i_b == '1);
    assign w_accInit   = w_isDivIn ? {{(WIDTH+1){1'b0}}, w_absA} : {{(WIDTH+1){1'b0}}, w_absB};
    assign w_operandIn = w_isDivIn ? w_absB : w_absA;

    assign w_opDiv = (r_op == OP_DIVU) | (r_op == OP_DIVS);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_mode    (w_opDiv),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_stepAcc),
        .o_carry   (w_carry)
    );

    assign w_next = w_opDiv ? {w_stepAcc[2*WIDTH:1], ~w_carry} : w_stepAcc;

    assign w_prod    = r_acc[2*WIDTH-1:0];
    assign w_prodFix = r_negP ? (~w_prod + 1'b1) : w_prod;
    assign w_quo     = r_acc[WIDTH-1:0];
    assign w_rem     = r_acc[2*WIDTH-1:WIDTH];
    assign w_loFix   = w_opDiv ? (r_negQ ? (~w_quo + 1'b1) : w_quo) : w_prodFix[WIDTH-1:0];
    assign w_hiFix   = w_opDiv ? (r_negR ? (~w_rem + 1'b1) : w_rem) : w_prodFix[2*WIDTH-1:WIDTH];

    always_comb begin
        w_ovfFix = 1'b0;
        case (r_op)
            OP_MULU: w_ovfFix = (w_hiFix != '0);
            OP_MULS: w_ovfFix = (w_hiFix != {WIDTH{w_loFix[WIDTH-1]}});
            OP_DIVU: w_ovfFix = 1'b0;
            OP_DIVS: w_ovfFix = r_ovfCase;
            default: w_ovfFix = 1'b0;
        endcase
    end

    // Divide-by-zero skips RUN/FIX entirely and lands in DONE one cycle after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_MULU;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_negP    <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_ovfCase <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_ovf     <= 1'b0;
            r_dz      <= 1'b0;
            r_zf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_op      <= bus.i_op;
                        r_negP    <= w_signA ^ w_signB;
                        r_negQ    <= w_signA ^ w_signB;
                        r_negR    <= w_signA;
                        r_ovfCase <= w_ovfCaseIn;
                        r_cnt     <= CNT_W'(WIDTH);
                        r_ovf     <= 1'b0;
                        r_zf      <= 1'b0;
                        if (w_dzIn) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_lo      <= '1;
                            r_hi      <= bus.i_a;
                            r_dz      <= 1'b1;
                            r_acc     <= '0;
                            r_operand <= '0;
                        end else begin
                            r_state   <= ST_RUN;
                            r_busy    <= 1'b1;
                            r_dz      <= 1'b0;
                            r_acc     <= w_accInit;
                            r_operand <= w_operandIn;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_lo    <= w_loFix;
                    r_hi    <= w_hiFix;
                    r_ovf   <= w_ovfFix;
                    r_zf    <= (w_loFix == '0);
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_lo   = r_lo;
    assign bus.o_hi   = r_hi;
    assign bus.o_ovf  = r_ovf;
    assign bus.o_dz   = r_dz;
    assign bus.o_zf   = r_zf;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=8 with hand-computed results.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk;
    logic rstN;
    int   checkCount;
    int   passCount;

    muldiv_if #(.WIDTH(8)) bus ();

    muldiv_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (rstN),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; start is held over exactly one rising edge.
    task automatic applyStimulus(input string tag, input op_e op, input logic [7:0] a,
                                 input logic [7:0] b, input int expCycles,
                                 input logic [7:0] expLo, input logic [7:0] expHi,
                                 input logic expOvf, input logic expDz, input logic expZf);
        int cycles;
        int busyCycles;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        cycles     = 0;
        busyCycles = 0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (bus.o_done) break;
            if (bus.o_busy) busyCycles++;
        end
        checkOutput({tag, ".doneCycle"}, 32'(cycles), 32'(expCycles));
        checkOutput({tag, ".busyCycles"}, 32'(busyCycles), 32'(expCycles - 1));
        checkOutput({tag, ".lo"}, 32'(bus.o_lo), 32'(expLo));
        checkOutput({tag, ".hi"}, 32'(bus.o_hi), 32'(expHi));
        checkOutput({tag, ".ovf"}, 32'(bus.o_ovf), 32'(expOvf));
        checkOutput({tag, ".dz"}, 32'(bus.o_dz), 32'(expDz));
        checkOutput({tag, ".zf"}, 32'(bus.o_zf), 32'(expZf));
    endtask

    initial begin
        int n;
        checkCount  = 0;
        passCount   = 0;
        rstN        = 1'b0;
        bus.i_start = 1'b0;
        bus.i_op    = OP_MULU;
        bus.i_a     = '0;
        bus.i_b     = '0;

        #23;
        checkOutput("reset.busy", 32'(bus.o_busy), 32'd0);
        checkOutput("reset.done", 32'(bus.o_done), 32'd0);
        checkOutput("reset.lo", 32'(bus.o_lo), 32'd0);
        checkOutput("reset.hi", 32'(bus.o_hi), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        applyStimulus("mulu200x3", OP_MULU, 8'd200, 8'd3, 10, 8'h58, 8'h02, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("hold.lo", 32'(bus.o_lo), 32'h58);
        checkOutput("hold.done", 32'(bus.o_done), 32'd0);
        checkOutput("hold.busy", 32'(bus.o_busy), 32'd0);

        applyStimulus("mulsM3x5", OP_MULS, 8'hFD, 8'd5, 10, 8'hF1, 8'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus("divu200d7", OP_DIVU, 8'd200, 8'd7, 10, 8'h1C, 8'h04, 1'b0, 1'b0, 1'b0);
        applyStimulus("divsM7d2", OP_DIVS, 8'hF9, 8'd2, 10, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus("divsMinDm1", OP_DIVS, 8'h80, 8'hFF, 10, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus("divuByZero", OP_DIVU, 8'h55, 8'h00, 1, 8'hFF, 8'h55, 1'b0, 1'b1, 1'b0);
        applyStimulus("mulu0x9", OP_MULU, 8'h00, 8'd9, 10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        // Re-pulsing start in RUN (cycle 3) and FIX (cycle 9) must not disturb 13*11.
        repeat (2) @(negedge clk);
        bus.i_op    = OP_MULU;
        bus.i_a     = 8'd13;
        bus.i_b     = 8'd11;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            bus.i_start = (n == 3) || (n == 9);
            if (bus.i_start) begin
                bus.i_a = 8'h77;
                bus.i_b = 8'h66;
            end
            if (bus.o_done) break;
        end
        bus.i_start = 1'b0;
        checkOutput("ignore.doneCycle", 32'(n), 32'd10);
        checkOutput("ignore.lo", 32'(bus.o_lo), 32'h8F);
        checkOutput("ignore.hi", 32'(bus.o_hi), 32'h00);

        repeat (2) @(negedge clk);
        bus.i_op    = OP_DIVS;
        bus.i_a     = 8'hF9;
        bus.i_b     = 8'd2;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midRst.busyBefore", 32'(bus.o_busy), 32'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midRst.busy", 32'(bus.o_busy), 32'd0);
        checkOutput("midRst.done", 32'(bus.o_done), 32'd0);
        checkOutput("midRst.lo", 32'(bus.o_lo), 32'd0);
        checkOutput("midRst.hi", 32'(bus.o_hi), 32'd0);
        checkOutput("midRst.flags", 32'({bus.o_ovf, bus.o_dz, bus.o_zf}), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        applyStimulus("mulu15x15", OP_MULU, 8'd15, 8'd15, 10, 8'hE1, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
